ps2_key_decoder: RTL and testbench

Produces the 5-bit held-key vector `key` consumed by the car controller. It receives raw PS/2 keyboard clock and data lines and deserialises 11-bit frames. It tracks make/break/extended prefixes and maintains one level bit per mapped key: high while held, low after release. It sits between the board PS/2 pins and the game-logic `key` input, all in the `pclk` domain.

---
 rtl/ps2_key_decoder.sv | 208 ++++++++++++++++++++
 tb/tb_ps2_key_decoder.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder
// Deserialises PS/2 keyboard frames and keeps a held/released level bit for
// each of the five keys the car controller cares about.
//
// Ports:
//   pclk       system clock, everything on the rising edge
//   rst_n      asynchronous active-low reset
//   ps2_clk    raw PS/2 clock (asynchronous to pclk)
//   ps2_data   raw PS/2 data  (asynchronous to pclk)
//   key        held keys: bit0 up, bit1 down, bit2 left, bit3 right, bit4 space
//   scan_code  last accepted byte
//   scan_valid one-cycle pulse when scan_code is new
//   frame_err  one-cycle pulse when a frame is discarded
//
// Optional build macro PS2_PARITY_CHECK_EN: when defined, a frame is accepted
// only if the 8 data bits plus the parity bit have odd parity. When it is not
// defined, the parity bit is consumed but not checked.
module ps2_key_decoder #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 65000
) (
  input  logic       pclk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [4:0] key,
  output logic [7:0] scan_code,
  output logic       scan_valid,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DATA   = 2'd1;
  localparam logic [1:0] PARITY = 2'd2;
  localparam logic [1:0] STOP   = 2'd3;

  logic [1:0]    clk_sync;
  logic [1:0]    data_sync;
  logic          clk_filt;
  logic          clk_filt_d;
  logic [FW-1:0] filt_cnt;
  logic          strobe;
  logic          data_bit;

  logic [1:0]    state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic [TW-1:0] tcnt;
  logic          timeout;
  logic          stop_ok;

  logic          ext;
  logic          brk;
  logic          map_hit;
  logic [2:0]    map_idx;

  // Synchronisers reset to the idle-high line level so that no edge is seen
  // on reset release.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

  // The filtered clock flips only after FILTER_LEN consecutive samples that
  // disagree with it; any agreeing sample restarts the count, so short
  // glitches never reach the edge detector.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      clk_filt   <= 1'b1;
      clk_filt_d <= 1'b1;
      filt_cnt   <= '0;
    end else begin
      clk_filt_d <= clk_filt;
      if (clk_sync[1] == clk_filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
        clk_filt <= clk_sync[1];
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + FW'(1);
      end
    end
  end

  assign strobe   = clk_filt_d & ~clk_filt;
  assign data_bit = data_sync[1];
  assign timeout  = (state != IDLE) && !strobe &&
                    (tcnt == TW'(TIMEOUT_CYCLES - 1));

`ifdef PS2_PARITY_CHECK_EN
  logic par;
  assign stop_ok = data_bit & (^{shift, par});
`else
  assign stop_ok = data_bit;
`endif

  // Frame deserialiser. The stall counter restarts on every strobe; if the
  // keyboard stops clocking mid-frame the partial byte is dropped.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shift      <= '0;
      tcnt       <= '0;
      scan_code  <= '0;
      scan_valid <= 1'b0;
      frame_err  <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      par        <= 1'b0;
`endif
    end else begin
      scan_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (timeout) begin
        state     <= IDLE;
        tcnt      <= '0;
        frame_err <= 1'b1;
      end else begin
        if (strobe) begin
          tcnt <= '0;
        end else if (state != IDLE) begin
          tcnt <= tcnt + TW'(1);
        end
        if (strobe) begin
          case (state)
            IDLE: begin
              if (!data_bit) begin
                state   <= DATA;
                bit_cnt <= '0;
              end
            end
            DATA: begin
              shift   <= {data_bit, shift[7:1]};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                state <= PARITY;
              end
            end
            PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
              par   <= data_bit;
`endif
              state <= STOP;
            end
            default: begin
              state <= IDLE;
              if (stop_ok) begin
                scan_code  <= shift;
                scan_valid <= 1'b1;
              end else begin
                frame_err <= 1'b1;
              end
            end
          endcase
        end
      end
    end
  end

  // Scan code to key-bit lookup; space is only recognised without E0.
  always_comb begin
    map_hit = 1'b0;
    map_idx = 3'd0;
    case (scan_code)
      8'h75: begin map_hit = 1'b1; map_idx = 3'd0; end
      8'h72: begin map_hit = 1'b1; map_idx = 3'd1; end
      8'h6B: begin map_hit = 1'b1; map_idx = 3'd2; end
      8'h74: begin map_hit = 1'b1; map_idx = 3'd3; end
      8'h29: begin map_hit = ~ext; map_idx = 3'd4; end
      default: begin map_hit = 1'b0; map_idx = 3'd0; end
    endcase
  end

  // Prefix tracking and key levels, updated the cycle after scan_valid.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      key <= '0;
      ext <= 1'b0;
      brk <= 1'b0;
    end else if (scan_valid) begin
      case (scan_code)
        8'hE0: ext <= 1'b1;
        8'hF0: brk <= 1'b1;
        8'hAA, 8'hFC: begin
          key <= '0;
          ext <= 1'b0;
          brk <= 1'b0;
        end
        default: begin
          ext <= 1'b0;
          brk <= 1'b0;
          if (map_hit) begin
            key[map_idx] <= ~brk;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder
// Drives randomized and directed PS/2 frames into ps2_key_decoder and compares
// key, scan_code, scan_valid and frame_err against a behavioural model.
// Honours PS2_PARITY_CHECK_EN the same way the design does.
module tb_ps2_key_decoder;

  localparam int FILT = 8;
  localparam int TMO  = 400;

  logic       pclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [4:0] key;
  logic [7:0] scan_code;
  logic       scan_valid;
  logic       frame_err;

  int checks = 0;
  int passes = 0;

  logic [7:0] byteQ[$];
  int         errPending = 0;
  logic [4:0] mKey = '0;
  logic       mExt = 1'b0;
  logic       mBrk = 1'b0;

  ps2_key_decoder #(.FILTER_LEN(FILT), .TIMEOUT_CYCLES(TMO)) dut (
    .pclk(pclk),
    .rst_n(rst_n),
    .ps2_clk(ps2_clk),
    .ps2_data(ps2_data),
    .key(key),
    .scan_code(scan_code),
    .scan_valid(scan_valid),
    .frame_err(frame_err)
  );

  always #5 pclk = ~pclk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Behavioural key model: prefixes set flags, mapped codes set/clear a bit,
  // BAT results wipe everything.
  task automatic modelByte(input logic [7:0] b);
    int idx;
    idx = -1;
    if (b == 8'hE0) mExt = 1'b1;
    else if (b == 8'hF0) mBrk = 1'b1;
    else if (b == 8'hAA || b == 8'hFC) begin
      mKey = '0; mExt = 1'b0; mBrk = 1'b0;
    end else begin
      if (b == 8'h75) idx = 0;
      if (b == 8'h72) idx = 1;
      if (b == 8'h6B) idx = 2;
      if (b == 8'h74) idx = 3;
      if (b == 8'h29 && !mExt) idx = 4;
      if (idx >= 0) mKey[idx] = !mBrk;
      mExt = 1'b0; mBrk = 1'b0;
    end
  endtask

  // Per-cycle compare against the model.
  always @(negedge pclk) begin
    if (!rst_n) begin
      mKey = '0; mExt = 1'b0; mBrk = 1'b0;
      byteQ.delete();
      errPending = 0;
    end else begin
      checkOutput("key", 32'(key), 32'(mKey));
      if (scan_valid) begin
        if (byteQ.size() == 0) begin
          checks++;
          $display("[TB] FAIL scan_valid: got pulse with code %0h expected no pulse", scan_code);
        end else begin
          logic [7:0] e;
          e = byteQ.pop_front();
          checkOutput("scan_code", 32'(scan_code), 32'(e));
          modelByte(e);
        end
      end
      if (frame_err) begin
        checks++;
        if (errPending == 0) $display("[TB] FAIL frame_err: got pulse expected none");
        else begin
          errPending--;
          passes++;
        end
      end
    end
  end

  task automatic driveBit(input logic d);
    int h;
    h = $urandom_range(14, 20);
    ps2_data = d;
    repeat (h) @(negedge pclk);
    ps2_clk = 1'b0;
    repeat (h) @(negedge pclk);
    ps2_clk = 1'b1;
  endtask

  task automatic applyStimulus(input logic [7:0] b, input logic goodStop, input logic goodParity);
    logic p;
    logic ok;
    p = ~(^b);
    if (!goodParity) p = ~p;
`ifdef PS2_PARITY_CHECK_EN
    ok = goodStop && goodParity;
`else
    ok = goodStop;
`endif
    if (ok) byteQ.push_back(b);
    else errPending++;
    driveBit(1'b0);
    for (int i = 0; i < 8; i++) driveBit(b[i]);
    driveBit(p);
    driveBit(goodStop);
    ps2_data = 1'b1;
    repeat (40) @(negedge pclk);
  endtask

  task automatic checkIdle(input string name);
    checkOutput({name, " pending bytes"}, 32'(byteQ.size()), 32'd0);
    checkOutput({name, " pending errs"}, 32'(errPending), 32'd0);
  endtask

  initial begin
    logic [7:0] codes [12];
    codes = '{8'hE0, 8'hF0, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h29, 8'hAA, 8'hFC, 8'h75, 8'h6B, 8'h00};

    repeat (3) @(negedge pclk);
    checkOutput("reset key", 32'(key), 32'd0);
    checkOutput("reset scan_code", 32'(scan_code), 32'd0);
    checkOutput("reset scan_valid", 32'(scan_valid), 32'd0);
    checkOutput("reset frame_err", 32'(frame_err), 32'd0);
    rst_n = 1'b1;
    repeat (10) @(negedge pclk);

    applyStimulus(8'hE0, 1, 1);
    applyStimulus(8'h75, 1, 1);
    checkOutput("E0 75 key", 32'(key), 32'h01);
    applyStimulus(8'hE0, 1, 1);
    applyStimulus(8'hF0, 1, 1);
    applyStimulus(8'h75, 1, 1);
    checkOutput("E0 F0 75 key", 32'(key), 32'h00);

    applyStimulus(8'h6B, 1, 1);
    applyStimulus(8'h29, 1, 1);
    checkOutput("6B 29 key", 32'(key), 32'h14);
    applyStimulus(8'hF0, 1, 1);
    applyStimulus(8'h6B, 1, 1);
    checkOutput("break 6B key", 32'(key), 32'h10);
    checkIdle("directed");

    applyStimulus(8'h72, 0, 1);
    checkOutput("bad stop key", 32'(key), 32'h10);
    checkIdle("bad stop");

    errPending++;
    driveBit(1'b0);
    for (int i = 0; i < 3; i++) driveBit(1'($urandom_range(0, 1)));
    ps2_data = 1'b1;
    repeat (TMO + 60) @(negedge pclk);
    checkIdle("timeout");
    applyStimulus(8'h74, 1, 1);
    checkOutput("after timeout key", 32'(key), 32'h18);

    applyStimulus(8'hAA, 1, 1);
    applyStimulus(8'h74, 1, 0);
`ifdef PS2_PARITY_CHECK_EN
    checkOutput("bad parity key", 32'(key), 32'h00);
`else
    checkOutput("bad parity key", 32'(key), 32'h08);
`endif
    applyStimulus(8'hAA, 1, 1);
    applyStimulus(8'h75, 1, 1);
    applyStimulus(8'h72, 1, 1);
    checkOutput("up+down key", 32'(key), 32'h03);
    applyStimulus(8'hAA, 1, 1);
    checkOutput("BAT key", 32'(key), 32'h00);

    ps2_data = 1'b0;
    ps2_clk = 1'b0;
    repeat (FILT / 2) @(negedge pclk);
    ps2_clk = 1'b1;
    repeat (TMO + 60) @(negedge pclk);
    ps2_data = 1'b1;
    repeat (10) @(negedge pclk);
    checkIdle("glitch");

    for (int n = 0; n < 60; n++) begin
      logic [7:0] b;
      b = codes[$urandom_range(0, 11)];
      if (b == 8'h00) b = 8'($urandom_range(0, 255));
      applyStimulus(b, $urandom_range(0, 9) != 0, $urandom_range(0, 9) != 0);
    end
    checkIdle("random");

    driveBit(1'b0);
    driveBit(1'b1);
    driveBit(1'b0);
    @(negedge pclk);
    rst_n = 1'b0;
    #1;
    checkOutput("midframe reset key", 32'(key), 32'd0);
    checkOutput("midframe reset scan_code", 32'(scan_code), 32'd0);
    checkOutput("midframe reset scan_valid", 32'(scan_valid), 32'd0);
    checkOutput("midframe reset frame_err", 32'(frame_err), 32'd0);
    ps2_data = 1'b1;
    ps2_clk = 1'b1;
    repeat (5) @(negedge pclk);
    rst_n = 1'b1;
    repeat (TMO + 60) @(negedge pclk);
    applyStimulus(8'h75, 1, 1);
    checkOutput("post reset key", 32'(key), 32'h01);
    checkIdle("final");

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
